// File: rtl/alu_pipe_if.sv
// Handshake and data bundle for alu_pipe: operation in, result plus flags out.
// The driver side uses the master modport, the ALU uses slave.
interface alu_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       ALU_Sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Result;
   logic             Zero;
   logic             Carry;
   logic             Overflow;
   logic             Negative;

   modport master (
      output in_valid, A, B, ALU_Sel, out_ready,
      input  in_ready, out_valid, Result, Zero, Carry, Overflow, Negative
   );

   modport slave (
      input  in_valid, A, B, ALU_Sel, out_ready,
      output in_ready, out_valid, Result, Zero, Carry, Overflow, Negative
   );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined ALU: one op per cycle over valid/ready, NUM_STAGES result registers
// with back-pressure, and a carry register chained across add/sub ops.
module alu_pipe #(
   parameter int WIDTH      = 8,
   parameter int NUM_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   alu_pipe_if.slave  bus
);
   localparam int MSB = WIDTH - 1;

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic             zero;
      logic             carry;
      logic             overflow;
      logic             negative;
   } stage_t;

   logic                  carry_q;
   logic [NUM_STAGES-1:0] vld_q;
   stage_t                dat_q [NUM_STAGES];
   logic [NUM_STAGES-1:0] rdy;
   logic                  accept;

   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic               alu_v;
   logic [WIDTH:0]     sum_ext;
   logic [2*WIDTH-1:0] prod;
   logic               carry_upd;
   logic               carry_clr;
   stage_t             alu_out;

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      sum_ext = '0;
      prod    = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
      case (bus.ALU_Sel)
         4'd0: begin
            sum_ext = {1'b0, bus.A} + {1'b0, bus.B};
            alu_res = sum_ext[MSB:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = (bus.A[MSB] == bus.B[MSB]) && (alu_res[MSB] != bus.A[MSB]);
         end
         4'd1: begin
            // bit WIDTH of the extended difference is the borrow
            sum_ext = {1'b0, bus.A} - {1'b0, bus.B};
            alu_res = sum_ext[MSB:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = (bus.A[MSB] != bus.B[MSB]) && (alu_res[MSB] != bus.A[MSB]);
         end
         4'd2: begin
            sum_ext = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, carry_q};
            alu_res = sum_ext[MSB:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = (bus.A[MSB] == bus.B[MSB]) && (alu_res[MSB] != bus.A[MSB]);
         end
         4'd3: begin
            sum_ext = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, carry_q};
            alu_res = sum_ext[MSB:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = (bus.A[MSB] != bus.B[MSB]) && (alu_res[MSB] != bus.A[MSB]);
         end
         4'd4: alu_res = bus.A & bus.B;
         4'd5: alu_res = bus.A | bus.B;
         4'd6: alu_res = bus.A ^ bus.B;
         4'd7: alu_res = ~bus.A;
         4'd8: begin
            alu_res = {bus.A[MSB-1:0], 1'b0};
            alu_c   = bus.A[MSB];
         end
         4'd9: begin
            alu_res = {1'b0, bus.A[MSB:1]};
            alu_c   = bus.A[0];
         end
         4'd10: begin
            alu_res = {bus.A[MSB-1:0], bus.A[MSB]};
            alu_c   = bus.A[MSB];
         end
         4'd11: begin
            alu_res = {bus.A[0], bus.A[MSB:1]};
            alu_c   = bus.A[0];
         end
         4'd12: begin
            alu_res = prod[MSB:0];
            alu_c   = |prod[2*WIDTH-1:WIDTH];
         end
         4'd13: alu_res = bus.B;
         4'd14: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
         4'd15: alu_res = '0;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      alu_out.result   = alu_res;
      alu_out.zero     = (alu_res == '0);
      alu_out.carry    = alu_c;
      alu_out.overflow = alu_v;
      alu_out.negative = alu_res[MSB];
   end

   assign carry_upd = (bus.ALU_Sel <= 4'd3) ||
                      ((bus.ALU_Sel >= 4'd8) && (bus.ALU_Sel <= 4'd12));
   assign carry_clr = (bus.ALU_Sel == 4'd15);

   // A stage can take new contents if it is empty or its occupant moves on.
   always_comb begin
      rdy = '0;
      rdy[NUM_STAGES-1] = ~vld_q[NUM_STAGES-1] | bus.out_ready;
      for (int k = NUM_STAGES - 2; k >= 0; k--) begin
         rdy[k] = ~vld_q[k] | rdy[k+1];
      end
   end

   assign bus.in_ready = reset & rdy[0];
   assign accept       = bus.in_valid & bus.in_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_q   <= '0;
         carry_q <= 1'b0;
         for (int k = 0; k < NUM_STAGES; k++) begin
            dat_q[k] <= '0;
         end
      end else begin
         if (accept) begin
            if (carry_upd) begin
               carry_q <= alu_c;
            end else if (carry_clr) begin
               carry_q <= 1'b0;
            end
         end
         if (rdy[0]) begin
            vld_q[0] <= accept;
            if (accept) begin
               dat_q[0] <= alu_out;
            end
         end
         for (int k = 1; k < NUM_STAGES; k++) begin
            if (rdy[k]) begin
               vld_q[k] <= vld_q[k-1];
               if (vld_q[k-1]) begin
                  dat_q[k] <= dat_q[k-1];
               end
            end
         end
      end
   end

   assign bus.out_valid = vld_q[NUM_STAGES-1];
   assign bus.Result    = dat_q[NUM_STAGES-1].result;
   assign bus.Zero      = dat_q[NUM_STAGES-1].zero;
   assign bus.Carry     = dat_q[NUM_STAGES-1].carry;
   assign bus.Overflow  = dat_q[NUM_STAGES-1].overflow;
   assign bus.Negative  = dat_q[NUM_STAGES-1].negative;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=8, NUM_STAGES=2): directed cases plus a random
// stream scored against an integer-arithmetic model of the ALU.
module tb_alu_pipe;
   localparam int W  = 8;
   localparam int NS = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_pipe_if #(.WIDTH(W)) bus ();

   alu_pipe #(.WIDTH(W), .NUM_STAGES(NS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [7:0] r;
      logic       z;
      logic       c;
      logic       v;
      logic       n;
   } res_t;

   int   vectors    = 0;
   int   miscompares = 0;
   int   carry_m    = 0;
   res_t sb_q[$];

   function automatic res_t ref_alu(input int op, input int a, input int b,
                                    input int cin, output int cout);
      int   sa, sb, r, full, sv, p;
      bit   c, v;
      res_t o;
      sa = (a >= 128) ? a - 256 : a;
      sb = (b >= 128) ? b - 256 : b;
      r = 0; c = 0; v = 0; sv = 0; full = 0; p = 0;
      case (op)
         0:  begin full = a + b;       c = (full > 255);   sv = sa + sb;       r = full; end
         1:  begin full = a - b;       c = (a < b);        sv = sa - sb;       r = full; end
         2:  begin full = a + b + cin; c = (full > 255);   sv = sa + sb + cin; r = full; end
         3:  begin full = a - b - cin; c = (a < b + cin);  sv = sa - sb - cin; r = full; end
         4:  r = a & b;
         5:  r = a | b;
         6:  r = a ^ b;
         7:  r = 255 - a;
         8:  begin r = a * 2;                  c = (a >= 128); end
         9:  begin r = a / 2;                  c = (a % 2 == 1); end
         10: begin r = a * 2 + a / 128;        c = (a >= 128); end
         11: begin r = a / 2 + (a % 2) * 128; c = (a % 2 == 1); end
         12: begin p = a * b; r = p;           c = (p >= 256); end
         13: r = b;
         14: r = (sa < sb) ? 1 : 0;
         default: r = 0;
      endcase
      if (op <= 3) v = (sv > 127) || (sv < -128);
      r = r & 255;
      cout = cin;
      if (op <= 3 || (op >= 8 && op <= 12)) cout = c ? 1 : 0;
      else if (op == 15) cout = 0;
      o.r = r[7:0];
      o.z = (r == 0);
      o.c = c;
      o.v = v;
      o.n = (r >= 128);
      return o;
   endfunction

   // One clock: drive at negedge, observe handshakes 1ns later, return after posedge.
   task automatic step(input bit iv, input int op, input int a, input int b, input bit ordy,
                       output bit acc, output bit emit, output res_t got);
      @(negedge clk);
      bus.in_valid  = iv;
      bus.ALU_Sel   = op[3:0];
      bus.A         = a[7:0];
      bus.B         = b[7:0];
      bus.out_ready = ordy;
      #1;
      acc  = iv && bus.in_ready;
      emit = bus.out_valid && ordy;
      got  = {bus.Result, bus.Zero, bus.Carry, bus.Overflow, bus.Negative};
      @(posedge clk);
   endtask

   task automatic run_op(input int op, input int a, input int b,
                         output res_t got, output int lat, output bit ok);
      bit   acc, emit;
      res_t g;
      int   cyc, nc;
      res_t unused_exp;
      ok = 0; lat = 0; cyc = 0; acc = 0; emit = 0; got = '0;
      while (!acc && cyc < 20) begin
         step(1, op, a, b, 1, acc, emit, g);
         cyc++;
      end
      if (!acc) return;
      unused_exp = ref_alu(op, a, b, carry_m, nc);
      carry_m = nc;
      while (!emit && lat < 20) begin
         step(0, 0, 0, 0, 1, acc, emit, g);
         lat++;
      end
      ok  = emit;
      got = g;
   endtask

   task automatic test_reset();
      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      bus.ALU_Sel   = '0;
      bus.out_ready = 1'b1;
      #2;
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      end
      vectors++;
      if (bus.in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
      end
      vectors++;
      if ({bus.Result, bus.Zero, bus.Carry, bus.Overflow, bus.Negative} !== 12'h000) begin
         miscompares++;
         $display("FAIL reset_result_flags: got %h/%b%b%b%b expected 00/0000",
                  bus.Result, bus.Zero, bus.Carry, bus.Overflow, bus.Negative);
      end
      repeat (2) @(negedge clk);
      reset   = 1'b1;
      carry_m = 0;
   endtask

   task automatic test_add_adc();
      res_t got;
      int   lat;
      bit   ok;
      run_op(0, 8'hFF, 8'h01, got, lat, ok);
      vectors++;
      if (!ok || got !== res_t'({8'h00, 1'b1, 1'b1, 1'b0, 1'b0})) begin
         miscompares++;
         $display("FAIL add_ff_01: got %h (ok=%0b) expected %h", got, ok,
                  res_t'({8'h00, 1'b1, 1'b1, 1'b0, 1'b0}));
      end
      vectors++;
      if (lat != NS) begin
         miscompares++;
         $display("FAIL latency: got %0d cycles expected %0d", lat, NS);
      end
      run_op(2, 8'h00, 8'h00, got, lat, ok);
      vectors++;
      if (!ok || got !== res_t'({8'h01, 1'b0, 1'b0, 1'b0, 1'b0})) begin
         miscompares++;
         $display("FAIL adc_00_00: got %h (ok=%0b) expected %h", got, ok,
                  res_t'({8'h01, 1'b0, 1'b0, 1'b0, 1'b0}));
      end
   endtask

   task automatic test_sub_sbc();
      res_t got;
      int   lat;
      bit   ok;
      run_op(1, 8'h80, 8'h01, got, lat, ok);
      vectors++;
      if (!ok || got !== res_t'({8'h7F, 1'b0, 1'b0, 1'b1, 1'b0})) begin
         miscompares++;
         $display("FAIL sub_80_01: got %h (ok=%0b) expected %h", got, ok,
                  res_t'({8'h7F, 1'b0, 1'b0, 1'b1, 1'b0}));
      end
      run_op(3, 8'h05, 8'h05, got, lat, ok);
      vectors++;
      if (!ok || got !== res_t'({8'h00, 1'b1, 1'b0, 1'b0, 1'b0})) begin
         miscompares++;
         $display("FAIL sbc_05_05: got %h (ok=%0b) expected %h", got, ok,
                  res_t'({8'h00, 1'b1, 1'b0, 1'b0, 1'b0}));
      end
   endtask

   task automatic test_mul_ror();
      res_t got;
      int   lat;
      bit   ok;
      run_op(12, 8'h10, 8'h10, got, lat, ok);
      vectors++;
      if (!ok || got !== res_t'({8'h00, 1'b1, 1'b1, 1'b0, 1'b0})) begin
         miscompares++;
         $display("FAIL mul_10_10: got %h (ok=%0b) expected %h", got, ok,
                  res_t'({8'h00, 1'b1, 1'b1, 1'b0, 1'b0}));
      end
      run_op(11, 8'h01, 8'h00, got, lat, ok);
      vectors++;
      if (!ok || got !== res_t'({8'h80, 1'b0, 1'b1, 1'b0, 1'b1})) begin
         miscompares++;
         $display("FAIL ror_01: got %h (ok=%0b) expected %h", got, ok,
                  res_t'({8'h80, 1'b0, 1'b1, 1'b0, 1'b1}));
      end
   endtask

   task automatic test_backpressure();
      bit   acc, emit;
      res_t got, exp;
      int   idx, nc, emits, first_cyc, last_cyc, a, b;
      idx = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         a = (idx * 70 + 200) % 256;
         b = idx + 1;
         step(1, 0, a, b, 0, acc, emit, got);
         if (acc) begin
            sb_q.push_back(ref_alu(0, a, b, carry_m, nc));
            carry_m = nc;
            idx++;
         end
      end
      vectors++;
      if (idx != NS) begin
         miscompares++;
         $display("FAIL bp_accepted: got %0d ops expected %0d", idx, NS);
      end
      #1;
      vectors++;
      if (bus.in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_in_ready_full: got %b expected 0", bus.in_ready);
      end
      emits = 0; first_cyc = -1; last_cyc = -1;
      for (int cyc = 0; cyc < 12 && emits < 4; cyc++) begin
         a = (idx * 70 + 200) % 256;
         b = idx + 1;
         step(idx < 4, 0, a, b, 1, acc, emit, got);
         if (emit) begin
            exp = sb_q.pop_front();
            vectors++;
            if (got !== exp) begin
               miscompares++;
               $display("FAIL bp_order[%0d]: got %h expected %h", emits, got, exp);
            end
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            emits++;
         end
         if (acc) begin
            sb_q.push_back(ref_alu(0, a, b, carry_m, nc));
            carry_m = nc;
            idx++;
         end
      end
      vectors++;
      if (emits != 4 || last_cyc - first_cyc != 3) begin
         miscompares++;
         $display("FAIL bp_drain: got %0d results over %0d cycles expected 4 over 4",
                  emits, last_cyc - first_cyc + 1);
      end
   endtask

   task automatic test_reset_midflight();
      bit   acc, emit;
      res_t got;
      int   lat, n_acc, nc, cyc;
      bit   ok;
      res_t unused_exp;
      n_acc = 0; cyc = 0;
      while (n_acc < 2 && cyc < 10) begin
         if (n_acc == 0) step(1, 0, 8'hFF, 8'h01, 0, acc, emit, got);
         else            step(1, 13, 8'h00, 8'h33, 0, acc, emit, got);
         if (acc) begin
            unused_exp = ref_alu(n_acc == 0 ? 0 : 13, n_acc == 0 ? 255 : 0,
                                 n_acc == 0 ? 1 : 51, carry_m, nc);
            carry_m = nc;
            n_acc++;
         end
         cyc++;
      end
      bus.in_valid = 1'b0;
      #2;
      vectors++;
      if (bus.out_valid !== 1'b1 || carry_m != 1) begin
         miscompares++;
         $display("FAIL midflight_setup: got out_valid=%b carry=%0d expected 1/1",
                  bus.out_valid, carry_m);
      end
      reset = 1'b0;
      #1;
      vectors++;
      if (bus.out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL midflight_reset_out_valid: got %b expected 0", bus.out_valid);
      end
      sb_q.delete();
      carry_m = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      run_op(2, 8'h01, 8'h01, got, lat, ok);
      vectors++;
      if (!ok || got !== res_t'({8'h02, 1'b0, 1'b0, 1'b0, 1'b0})) begin
         miscompares++;
         $display("FAIL adc_after_reset: got %h (ok=%0b) expected %h", got, ok,
                  res_t'({8'h02, 1'b0, 1'b0, 1'b0, 1'b0}));
      end
   endtask

   task automatic test_random();
      bit   acc, emit, iv, ordy;
      res_t got, exp;
      int   op, a, b, nc, n_acc, n_emit, cyc;
      n_acc = 0; n_emit = 0; cyc = 0;
      op = $urandom_range(0, 15); a = $urandom_range(0, 255); b = $urandom_range(0, 255);
      while (n_acc < 1000 && cyc < 10000) begin
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         step(iv, op, a, b, ordy, acc, emit, got);
         if (emit) begin
            vectors++;
            if (sb_q.size() == 0) begin
               miscompares++;
               $display("FAIL rand_extra: got %h expected no result", got);
            end else begin
               exp = sb_q.pop_front();
               if (got !== exp) begin
                  miscompares++;
                  $display("FAIL rand[%0d]: got %h expected %h", n_emit, got, exp);
               end
            end
            n_emit++;
         end
         if (acc) begin
            sb_q.push_back(ref_alu(op, a, b, carry_m, nc));
            carry_m = nc;
            n_acc++;
            op = $urandom_range(0, 15); a = $urandom_range(0, 255); b = $urandom_range(0, 255);
         end
         cyc++;
      end
      for (int d = 0; d < 20 && sb_q.size() > 0; d++) begin
         step(0, 0, 0, 0, 1, acc, emit, got);
         if (emit) begin
            exp = sb_q.pop_front();
            vectors++;
            if (got !== exp) begin
               miscompares++;
               $display("FAIL rand_drain[%0d]: got %h expected %h", n_emit, got, exp);
            end
            n_emit++;
         end
      end
      vectors++;
      if (n_acc != 1000 || n_emit != 1000 || sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL rand_count: got %0d accepted %0d emitted %0d pending expected 1000/1000/0",
                  n_acc, n_emit, sb_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_add_adc();
      test_sub_sbc();
      test_mul_ror();
      test_backpressure();
      test_reset_midflight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the team's single-cycle ALU. It accepts one operation per cycle through a valid/ready handshake and carries it through NUM_STAGES register stages with back-pressure. It keeps a carry register across operations to support multi-word add and subtract chains, and returns result plus Zero/Carry/Overflow/Negative flags. It sits between the operand sequencer and the result sink in the datapath and is driven directly by the environment's driver in the ALU verification bench.

## Interface
- WIDTH, 8: operand/result width, ≥4
- NUM_STAGES, 2: output pipeline depth, ≥1
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation can be accepted this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- ALU_Sel  in  4  opcode
- out_valid  out  1  result present
- out_ready  in  1  sink accepts result
- Result  out  WIDTH  result
- Zero, Carry, Overflow, Negative  out  1 each  flags travelling with Result

## Operation
- Accept when in_valid && in_ready at a rising edge. The op is computed combinationally from A, B, ALU_Sel and carry_q, then loaded into stage 1.
- Opcodes:
  - 0 ADD: A+B
  - 1 SUB: A−B
  - 2 ADC: A+B+carry_q
  - 3 SBC: A−B−carry_q
  - 4 AND, 5 OR, 6 XOR, 7 NOT: ~A
  - 8 SHL: A<<1, Carry=A[MSB]
  - 9 SHR (logical): Carry=A[0]
  - 10 ROL, 11 ROR: Carry = the rotated-out bit
  - 12 MUL: low WIDTH bits of A*B; Carry=1 if the high WIDTH bits are nonzero
  - 13 PASSB: Result=B
  - 14 SLT: Result=1 if signed A<B, else 0
  - 15 CLRC: Result=0, clears carry_q
- Carry rules:
  - ADD/ADC: carry out of bit WIDTH−1.
  - SUB/SBC: borrow, 1 when the unsigned minuend is less than the subtrahend plus borrow-in.
  - Logic ops, PASSB, SLT, CLRC: Carry=0.
- Overflow: signed overflow for opcodes 0–3 only; 0 otherwise.
- Zero = (Result==0). Negative = Result[WIDTH−1].
- carry_q: updated at acceptance by opcodes 0–3 and 8–12 (takes that op's Carry). Cleared by CLRC. Unchanged by all other ops.
- Pipeline: stages S1..S_NUM_STAGES, each holding {valid, Result, flags}.
  - Stage k advances when stage k+1 is empty or advancing.
  - The last stage empties when out_ready=1.
  - in_ready = S1 empty or S1 advancing (combinational).
- Ordering: results leave in acceptance order. No drop, no duplication.

## Timing
- Reset (reset=0):
  - All stage valid bits = 0, out_valid = 0, Result and flags = 0, carry_q = 0.
  - in_ready is forced 0 while reset is low.
  - Effect is immediate (asynchronous). Deassertion is synchronised by the integrator.
- Latency: with an empty pipe and out_ready=1, an op accepted at edge t is on the outputs after edge t+NUM_STAGES−1. NUM_STAGES=1 means visible right after the accepting edge.
- Throughput: 1 op/cycle while out_ready stays high.
- Output hold: while out_valid && !out_ready, Result and flags hold stable.
- Capacity: NUM_STAGES ops in flight. With out_ready low, in_ready drops once all stages are full.
- Simultaneous accept and emit when full: allowed. in_ready=1 whenever out_ready=1.
- Back-to-back ADC after ADD: uses the carry_q updated by the previous accepted op, with no bubble.
- Reset mid-operation: in-flight ops are discarded and carry_q is lost.

## Test plan
- WIDTH=8. ADD FF+01 → Result 00, Zero=1, Carry=1, Overflow=0. Then ADC 00+00 → Result 01, Carry=0.
- SUB 80−01 → Result 7F, Overflow=1, Carry=0, Negative=0. Then SBC 05−05 with carry_q=0 → Result 00, Zero=1.
- MUL 10*10 → Result 00, Carry=1, Zero=1. Then ROR 01 → Result 80, Carry=1, Negative=1.
- Back-pressure, NUM_STAGES=2, out_ready=0: offer 4 ADDs → exactly 2 accepted and in_ready=0. Raise out_ready → all 4 results appear in order, one per cycle.
- Reset mid-flight: 2 ops in flight, carry_q=1, assert reset → out_valid=0 immediately. After release, ADC 01+01 → Result 02.
- Random stream of 1000 ops with random out_ready → scoreboard matches the reference model including carry_q chaining. Results leave in order with none lost.
